// File: rtl/wb_prog_ctrl_pkg.sv
// wb_prog_ctrl_pkg: shared address map, config register indices and sequencer states
package wb_prog_ctrl_pkg;
  localparam logic [1:0] SPACE_INSTR = 2'b00;
  localparam logic [1:0] SPACE_CFG = 2'b01;
  localparam logic CFG_PROG = 1'b0;
  localparam logic CFG_PINDIR = 1'b1;
  typedef enum logic [1:0] {
    RUN = 2'b00,
    PROG = 2'b01,
    RELEASE = 2'b10
  } state_t;
endpackage

// File: rtl/wb_prog_ctrl_seq.sv
// prog_release_seq: holds cores while programming and releases them after a fixed settle delay
module prog_release_seq
  import wb_prog_ctrl_pkg::*;
#(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic core_halt,
  output logic prog_mode
);
  localparam int CW = $clog2(RELEASE_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      RUN: state_nx = set ? PROG : RUN;
      PROG: begin
        state_nx = clr ? RELEASE : PROG;
        cnt_nx = clr ? CW'(RELEASE_CYCLES) : cnt;
      end
      RELEASE: begin
        state_nx = set ? PROG : (cnt <= CW'(1)) ? RUN : RELEASE;
        cnt_nx = (set || cnt <= CW'(1)) ? '0 : cnt - CW'(1);
      end
      default: begin
        state_nx = RUN;
        cnt_nx = '0;
      end
    endcase
  end
  assign core_halt = state != RUN;
  assign prog_mode = state == PROG;
endmodule

// File: rtl/wb_prog_ctrl.sv
// wb_prog_ctrl: Wishbone slave for core programming, pin direction and core halt sequencing
module wb_prog_ctrl
  import wb_prog_ctrl_pkg::*;
#(
  parameter int CORES = 2,
  parameter int LOG_CORES = 1,
  parameter int PC_WIDTH = 3,
  parameter int INSTR_WIDTH = 32,
  parameter int IO_PINS = 8,
  parameter int WB_WIDTH = 32,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [WB_WIDTH-1:0]    wbs_adr_i,
  input  logic [WB_WIDTH-1:0]    wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [WB_WIDTH-1:0]    wbs_dat_o,
  output logic                   instr_we,
  output logic [LOG_CORES-1:0]   instr_core,
  output logic [PC_WIDTH-1:0]    instr_addr,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic                   core_halt,
  output logic [IO_PINS-1:0]     pin_dir,
  output logic                   prog_mode,
  output logic [7:0]             rej_cnt
);
  logic acc, wr, core_ok, instr_wr, instr_ok, cfg_wr, pin_wr, set, clr, unused_adr;
  logic [1:0] space;
  logic [LOG_CORES-1:0] core_sel;
  logic [PC_WIDTH-1:0] pc_sel;
  logic [WB_WIDTH-1:0] rd_data;
  assign acc = wbs_cyc_i & wbs_stb_i;
  assign wr = acc & wbs_we_i;
  assign space = wbs_adr_i[WB_WIDTH-1 -: 2];
  assign core_sel = wbs_adr_i[PC_WIDTH +: LOG_CORES];
  assign pc_sel = wbs_adr_i[PC_WIDTH-1:0];
  assign core_ok = 32'(core_sel) < CORES;
  assign instr_wr = wr & (space == SPACE_INSTR);
  assign instr_ok = instr_wr & prog_mode & core_ok;
  assign cfg_wr = wr & (space == SPACE_CFG);
  assign pin_wr = cfg_wr & (wbs_adr_i[0] == CFG_PINDIR);
  assign set = cfg_wr & (wbs_adr_i[0] == CFG_PROG) & wbs_dat_i[0];
  assign clr = cfg_wr & (wbs_adr_i[0] == CFG_PROG) & ~wbs_dat_i[0];
  assign unused_adr = ^wbs_adr_i[WB_WIDTH-3:PC_WIDTH+LOG_CORES];
  assign rd_data = (space != SPACE_CFG) ? '0 :
                   (wbs_adr_i[0] == CFG_PINDIR) ? {{(WB_WIDTH-IO_PINS){1'b0}}, pin_dir} :
                   {{(WB_WIDTH-1){1'b0}}, prog_mode};
  prog_release_seq #(.RELEASE_CYCLES(RELEASE_CYCLES)) u_seq (
    .clk(wb_clk_i),
    .rst_n(wb_rst_ni),
    .set(set),
    .clr(clr),
    .core_halt(core_halt),
    .prog_mode(prog_mode)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      instr_we <= 1'b0;
      instr_core <= '0;
      instr_addr <= '0;
      instr_data <= '0;
      pin_dir <= '0;
      rej_cnt <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rd_data : '0;
      instr_we <= instr_ok;
      if (instr_ok) begin
        instr_core <= core_sel;
        instr_addr <= pc_sel;
        instr_data <= wbs_dat_i[INSTR_WIDTH-1:0];
      end
      if (pin_wr) pin_dir <= wbs_dat_i[IO_PINS-1:0];
      if (instr_wr && !instr_ok && rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_wb_prog_ctrl.sv
// tb_wb_prog_ctrl: scoreboard bench comparing wb_prog_ctrl against a behavioural model
module tb_wb_prog_ctrl;
  localparam int RC = 4;
  localparam int NCORES = 2;
  typedef struct {int edge_n; bit rd; logic [31:0] data;} ack_t;
  typedef struct {int edge_n; logic core; logic [2:0] pc; logic [31:0] data;} instr_t;
  logic clk = 0, rst_n = 0, stb = 0, cyc = 0, we = 0;
  logic [31:0] adr = 0, dat = 0;
  logic ack, iwe, icore, halt, pmode;
  logic [31:0] dat_o, idata;
  logic [2:0] iaddr;
  logic [7:0] pdir, rej;
  ack_t ack_q[$];
  instr_t instr_q[$];
  int e_n = 0, n_chk = 0, n_fail = 0;
  bit m_prog = 0;
  int m_rel_end = 0, m_rej = 0;
  logic [7:0] m_pin = 0;
  wb_prog_ctrl dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .instr_we(iwe), .instr_core(icore), .instr_addr(iaddr), .instr_data(idata),
    .core_halt(halt), .pin_dir(pdir), .prog_mode(pmode), .rej_cnt(rej)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, e_n);
    end
  endtask
  task automatic model_accept(input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rv;
    rv = (a[31:30] == 2'b01) ? (a[0] ? {24'd0, m_pin} : {31'd0, m_prog}) : 32'd0;
    ack_q.push_back('{e_n, !w, rv});
    if (w && a[31:30] == 2'b00) begin
      if (m_prog && int'(a[3]) < NCORES) instr_q.push_back('{e_n, a[3], a[2:0], d});
      else m_rej = (m_rej == 255) ? 255 : m_rej + 1;
    end else if (w && a[31:30] == 2'b01) begin
      if (a[0]) m_pin = d[7:0];
      else if (d[0] && !m_prog) begin
        m_prog = 1;
        m_rel_end = 0;
      end else if (!d[0] && m_prog) begin
        m_prog = 0;
        m_rel_end = e_n + RC;
      end
    end
  endtask
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat = d;
    @(posedge clk);
    e_n++;
    model_accept(w, a, d);
  endtask
  task automatic idle(input bit c = 0, input bit s = 0);
    @(negedge clk);
    cyc = c; stb = s & ~c; we = $urandom_range(0, 1); adr = $urandom; dat = $urandom;
    @(posedge clk);
    e_n++;
  endtask
  always @(negedge clk) begin
    if (ack_q.size() > 0 && ack_q[0].edge_n == e_n) begin
      ack_t a;
      a = ack_q.pop_front();
      chk("ack", ack, 1);
      if (a.rd) chk("rd_data", dat_o, a.data);
    end else chk("ack_idle", ack, 0);
    if (instr_q.size() > 0 && instr_q[0].edge_n == e_n) begin
      instr_t i;
      i = instr_q.pop_front();
      chk("instr_we", iwe, 1);
      chk("instr_core", icore, i.core);
      chk("instr_addr", iaddr, i.pc);
      chk("instr_data", idata, i.data);
    end else chk("instr_we_idle", iwe, 0);
    chk("core_halt", halt, m_prog || e_n < m_rel_end);
    chk("prog_mode", pmode, m_prog);
    chk("pin_dir", pdir, m_pin);
    chk("rej_cnt", rej, m_rej);
  end
  initial begin
    repeat (2) idle();
    rst_n = 1;
    bus(0, 32'h4000_0000, 0);
    bus(0, 32'h4000_0001, 0);
    bus(1, 32'h4000_0000, 1);
    bus(1, 32'h0000_0009, 32'h6006_0001);
    bus(1, 32'h0000_0000, 32'hA000_0000);
    bus(1, 32'h0000_0001, 32'hA000_0001);
    bus(1, 32'h0000_0002, 32'hA000_0002);
    bus(1, 32'h4000_0000, 0);
    bus(1, 32'h0000_0003, 32'hDEAD_BEEF);
    repeat (6) idle();
    for (int i = 0; i < 257; i++) bus(1, {28'd0, 4'($urandom)}, $urandom);
    bus(1, 32'h4000_0001, 32'h0000_00F0);
    bus(0, 32'h4000_0001, 0);
    bus(1, 32'h8000_0001, 32'hFFFF_FFFF);
    bus(0, 32'hC000_0000, 0);
    bus(1, 32'h4000_0000, 1);
    bus(1, 32'h4000_0000, 1);
    bus(1, 32'h4000_0000, 0);
    idle();
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h0000_0005; dat = 32'h1234_5678;
    #1 rst_n = 0;
    m_prog = 0; m_rel_end = 0; m_rej = 0; m_pin = 0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst_instr_we", iwe, 0);
    chk("rst_instr_core", icore, 0);
    chk("rst_instr_addr", iaddr, 0);
    chk("rst_instr_data", idata, 0);
    chk("rst_core_halt", halt, 0);
    chk("rst_pin_dir", pdir, 0);
    chk("rst_prog_mode", pmode, 0);
    chk("rst_rej_cnt", rej, 0);
    @(posedge clk);
    e_n++;
    @(negedge clk);
    rst_n = 1; cyc = 1; stb = 1; we = 0; adr = 32'h4000_0000; dat = 0;
    @(posedge clk);
    e_n++;
    model_accept(0, 32'h4000_0000, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int k;
      a = $urandom;
      k = $urandom_range(0, 6);
      case (k)
        0, 1: bus($urandom_range(0, 1), {2'b00, a[29:0]}, $urandom);
        2: bus($urandom_range(0, 1), {2'b01, a[29:1], 1'b0}, $urandom);
        3: bus($urandom_range(0, 1), {2'b01, a[29:1], 1'b1}, $urandom);
        4: bus($urandom_range(0, 1), {1'b1, a[30:0]}, $urandom);
        5: idle($urandom_range(0, 1), 1);
        default: repeat ($urandom_range(1, 5)) idle();
      endcase
    end
    repeat (8) idle();
    chk("ack_q_drained", ack_q.size(), 0);
    chk("instr_q_drained", instr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
